imem_fetch_port: RTL
====================

// Module: imem_fetch_port
// PURPOSE
//  Parametrised instruction memory with a valid/ready fetch port, a program-load write port and a fault flag.
//  Sits between the PC/fetch stage and the decode stage of the KGP-RISC core.
//  The load port lets the testbench or boot loader write the program after reset, with no $readmem needed.
//  One-entry registered response: back-pressure from decode stalls fetch without losing the word.
// PARAMETERS
//  DATA_W     32            instruction/word width in bits
//  DEPTH      32            number of words; any value >= 2, power of two not required
//  ADDR_W     32            width of req_addr and ld_addr
//  BYTE_ADDR  1             1: addresses are byte addresses, word index = addr>>2; 0: addresses are word indices
//  NOP_WORD   32'h00220000  content of every word at time 0; also returned on a faulting fetch
//  IDX_W      $clog2(DEPTH) localparam, width of the internal word index
// PORTS
//  clka       in   1       clock; all state updates on posedge
//  rsta_n     in   1       asynchronous, active-low reset
//  req_valid  in   1       fetch request valid
//  req_ready  out  1       fetch request accepted when req_valid && req_ready
//  req_addr   in   ADDR_W  fetch address
//  rsp_valid  out  1       response word valid
//  rsp_ready  in   1       decode consumes the response when rsp_valid && rsp_ready
//  rsp_data   out  DATA_W  fetched instruction
//  rsp_fault  out  1       response is a fault (misaligned or out of range)
//  flush      in   1       discard the pending response (branch redirect)
//  ld_we      in   1       program-load write strobe
//  ld_addr    in   ADDR_W  load address; same decoding as req_addr
//  ld_data    in   DATA_W  load data
//  ld_err     out  1       sticky flag: a load targeted a misaligned or out-of-range address
// BEHAVIOUR
//  Reset (rsta_n=0, asynchronous):
//   - rsp_valid=0, rsp_data=0, rsp_fault=0, ld_err=0.
//   - Memory array is NOT reset; it holds NOP_WORD in every word from time 0 (initial fill) and afterwards keeps whatever was written.
//  Decode, for a request or a load:
//   - BYTE_ADDR=1: misaligned when addr[1:0]!=0; idx=addr[IDX_W+1:2]. BYTE_ADDR=0: never misaligned; idx=addr[IDX_W-1:0].
//   - Out of range when the word number (addr>>2, or addr) >= DEPTH; all upper address bits are compared.
//  Handshake:
//   - req_ready = (!rsp_valid || rsp_ready) && !ld_we && !flush.
//   - Latency is 1: a fetch accepted in cycle N gives rsp_valid=1 in cycle N+1, with rsp_data = mem[idx] as read in cycle N.
//   - rsp_valid && !rsp_ready: rsp_data and rsp_fault hold stable. Back-to-back fetches sustain 1 word per cycle while rsp_ready=1.
//   - Fault fetch: rsp_fault=1 and rsp_data=NOP_WORD; the memory is not read.
//  States (2): EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
//   - EMPTY->FULL on accept. FULL->FULL on accept with consume. FULL->EMPTY on consume without accept, or on flush.
//  Load:
//   - ld_we=1 writes mem[idx]<=ld_data at the posedge when the address is valid. An invalid address leaves memory unchanged and sets ld_err.
//   - A load and a fetch never share a cycle, because ld_we forces req_ready=0. A pending response is unaffected by a later load to the same word.
//  Flush:
//   - flush=1 forces rsp_valid=0 next cycle, whatever rsp_ready is, and blocks acceptance that cycle.
//   - flush && ld_we in the same cycle: both take effect.
//  Reset mid-transfer: the pending response is dropped; memory contents are kept.
// STRUCTURE
//  - Shared package kgp_pkg: NOP_WORD constant and the DATA_W/ADDR_W defaults, shared with the data memory and decoder.
//  - One sub-module, imem_addr_decode (combinational; addr -> idx, misaligned, out_of_range), instantiated twice: fetch and load.
//  - Storage is an inferred single-port array with a synchronous read; the response register sits in this module.
// TESTING
//  1. Reset, then fetch addr 0x0, 0x4, 0x7C back-to-back with rsp_ready=1 -> three responses on consecutive cycles, each 32'h00220000, rsp_fault=0.
//  2. Load 0x0 <- 32'hDEADBEEF and 0x4 <- 32'h12345678, then fetch 0x4, 0x0 -> 32'h12345678, then 32'hDEADBEEF, each 1 cycle after its accept.
//  3. Fetch 0x8 with rsp_ready=0 held 3 cycles -> rsp_valid=1 with data stable and req_ready=0; on rsp_ready=1 the word is consumed and the next fetch is accepted that same cycle.
//  4. Fetch 0x6 and fetch 0x80 (DEPTH=32) -> rsp_fault=1 and rsp_data=32'h00220000 both times; load to 0x80 -> ld_err=1, memory unchanged.
//  5. With a response pending, assert flush -> rsp_valid=0 next cycle and req_ready=0 during the flush cycle; a ld_we cycle gives req_ready=0.
//  6. Drop rsta_n mid-stall -> rsp_valid=0 immediately; after release, fetch of a previously loaded address returns the loaded value.

Source files
------------

// File: rtl/kgp_pkg.sv
// ---------------------------------------------------------------------------
// kgp_pkg
// Shared definitions for the KGP-RISC memory-side blocks (instruction memory,
// data memory, decoder): default bus widths, the NOP encoding that fills an
// unloaded memory, the response-register state type and a small fault helper.
// ---------------------------------------------------------------------------
package kgp_pkg;

  localparam int          KGP_DATA_W   = 32;
  localparam int          KGP_ADDR_W   = 32;
  localparam logic [31:0] KGP_NOP_WORD = 32'h0022_0000;

  // Occupancy of the one-entry response register.
  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  // An access is refused when it is misaligned or points past the last word.
  function automatic logic addrFault(input logic misaligned, input logic outOfRange);
    return misaligned | outOfRange;
  endfunction

endpackage

// File: rtl/imem_addr_decode.sv
// ---------------------------------------------------------------------------
// imem_addr_decode
// Combinational address decoder shared by the fetch and load paths of the
// instruction memory. Turns a byte or word address into a word index and
// flags misaligned and out-of-range accesses.
// Ports:
//   addr_i        in   ADDR_W  address to decode
//   idx_o         out  IDX_W   word index into the memory array
//   misaligned_o  out  1       byte address not on a word boundary
//   outOfRange_o  out  1       word number is DEPTH or above
// ---------------------------------------------------------------------------
module imem_addr_decode #(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 32,
  parameter int BYTE_ADDR = 1,
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              misaligned_o,
  output logic              outOfRange_o
);

  logic [ADDR_W-1:0] wordNum;

  // The word number keeps every upper address bit, so an address that would
  // alias back into the array after truncation is still caught as out of range.
  generate
    if (BYTE_ADDR != 0) begin : gByteAddr
      assign wordNum      = {2'b00, addr_i[ADDR_W-1:2]};
      assign misaligned_o = |addr_i[1:0];
    end else begin : gWordAddr
      assign wordNum      = addr_i;
      assign misaligned_o = 1'b0;
    end
  endgenerate

  assign idx_o        = wordNum[IDX_W-1:0];
  assign outOfRange_o = (wordNum >= ADDR_W'(DEPTH));

endmodule

// File: rtl/imem_fetch_port.sv
// ---------------------------------------------------------------------------
// imem_fetch_port
// Instruction memory for the KGP-RISC fetch stage. A valid/ready request port
// feeds a one-entry registered response toward decode, so back-pressure stalls
// fetch without losing a word. A separate load port writes the program after
// reset; bad load addresses raise a sticky error flag.
// Ports:
//   clka       in   1       clock
//   rsta_n     in   1       asynchronous active-low reset
//   req_valid  in   1       fetch request valid
//   req_ready  out  1       fetch request can be accepted this cycle
//   req_addr   in   ADDR_W  fetch address
//   rsp_valid  out  1       response word valid
//   rsp_ready  in   1       decode takes the response this cycle
//   rsp_data   out  DATA_W  fetched instruction (NOP_WORD on a fault)
//   rsp_fault  out  1       fetch was misaligned or out of range
//   flush      in   1       drop the pending response (branch redirect)
//   ld_we      in   1       program-load write strobe
//   ld_addr    in   ADDR_W  program-load address
//   ld_data    in   DATA_W  program-load data
//   ld_err     out  1       sticky: a load hit a misaligned/out-of-range address
// ---------------------------------------------------------------------------
module imem_fetch_port
  import kgp_pkg::*;
#(
  parameter int                DATA_W    = KGP_DATA_W,
  parameter int                DEPTH     = 32,
  parameter int                ADDR_W    = KGP_ADDR_W,
  parameter int                BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(KGP_NOP_WORD)
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  input  logic              flush,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err
);

  localparam int IDX_W = $clog2(DEPTH);

  // Storage is never reset; the declaration fill gives every word the NOP
  // encoding at time 0 so an unloaded program executes harmlessly.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

  rsp_state_e        state_q, state_d;
  logic [DATA_W-1:0] rspData_q;
  logic              rspFault_q;
  logic              ldErr_q;

  logic [IDX_W-1:0]  fetchIdx, loadIdx;
  logic              fetchMis, fetchOor, loadMis, loadOor;
  logic              fetchFault, loadFault;
  logic              accept, consume;

  imem_addr_decode #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BYTE_ADDR (BYTE_ADDR),
    .IDX_W     (IDX_W)
  ) uFetchDecode (
    .addr_i       (req_addr),
    .idx_o        (fetchIdx),
    .misaligned_o (fetchMis),
    .outOfRange_o (fetchOor)
  );

  imem_addr_decode #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BYTE_ADDR (BYTE_ADDR),
    .IDX_W     (IDX_W)
  ) uLoadDecode (
    .addr_i       (ld_addr),
    .idx_o        (loadIdx),
    .misaligned_o (loadMis),
    .outOfRange_o (loadOor)
  );

  assign fetchFault = addrFault(fetchMis, fetchOor);
  assign loadFault  = addrFault(loadMis, loadOor);
  assign accept     = req_valid && req_ready;
  assign consume    = rsp_valid && rsp_ready;

  // Response occupancy register.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= RSP_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: flush wins over everything; a full register only stays full
  // when it is refilled in the same cycle it is consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RSP_EMPTY: begin
        if (accept) begin
          state_d = RSP_FULL;
        end
      end
      RSP_FULL: begin
        if (flush) begin
          state_d = RSP_EMPTY;
        end else if (consume && !accept) begin
          state_d = RSP_EMPTY;
        end
      end
      default: state_d = RSP_EMPTY;
    endcase
  end

  // Handshake outputs. A load or flush cycle blocks acceptance, which is what
  // keeps loads and fetches from ever sharing a cycle.
  always_comb begin
    rsp_valid = (state_q == RSP_FULL);
    req_ready = (!rsp_valid || rsp_ready) && !ld_we && !flush;
  end

  // Response word and fault flag. The memory read happens here, so the array
  // read is synchronous and the word is held while decode stalls.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      rspData_q  <= '0;
      rspFault_q <= 1'b0;
    end else if (accept) begin
      rspFault_q <= fetchFault;
      rspData_q  <= fetchFault ? NOP_WORD : mem[fetchIdx];
    end
  end

  // Program load; a bad address leaves the array untouched.
  always_ff @(posedge clka) begin
    if (ld_we && !loadFault) begin
      mem[loadIdx] <= ld_data;
    end
  end

  // Sticky load error, cleared only by reset.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      ldErr_q <= 1'b0;
    end else if (ld_we && loadFault) begin
      ldErr_q <= 1'b1;
    end
  end

  assign rsp_data  = rspData_q;
  assign rsp_fault = rspFault_q;
  assign ld_err    = ldErr_q;

endmodule
